// File: rtl/sisc_pkg.sv
// Shared definitions for the SISC control slice: FSM states, opcodes,
// ALU mode codes and ALU function codes.
package sisc_pkg;

  typedef enum logic [2:0] {
    S_START0    = 3'd0,
    S_START1    = 3'd1,
    S_FETCH     = 3'd2,
    S_DECODE    = 3'd3,
    S_EXECUTE   = 3'd4,
    S_MEM       = 3'd5,
    S_WRITEBACK = 3'd6,
    S_HALT      = 3'd7
  } state_t;

  localparam logic [3:0] OP_NOP    = 4'b0000;
  localparam logic [3:0] OP_ALU_RR = 4'b0001;
  localparam logic [3:0] OP_ALU_RI = 4'b0010;
  localparam logic [3:0] OP_ADDI   = 4'b0011;
  localparam logic [3:0] OP_SUBI   = 4'b0100;
  localparam logic [3:0] OP_INC    = 4'b0101;
  localparam logic [3:0] OP_DEC    = 4'b0110;
  localparam logic [3:0] OP_MOV    = 4'b0111;
  localparam logic [3:0] OP_HLT    = 4'b1111;

  localparam logic [2:0] MODE_RR   = 3'b000;
  localparam logic [2:0] MODE_RI   = 3'b001;
  localparam logic [2:0] MODE_ADDI = 3'b010;
  localparam logic [2:0] MODE_SUBI = 3'b011;
  localparam logic [2:0] MODE_INC  = 3'b100;
  localparam logic [2:0] MODE_DEC  = 3'b101;
  localparam logic [2:0] MODE_MOV  = 3'b110;
  localparam logic [2:0] MODE_RSVD = 3'b111;

  localparam logic [3:0] FN_NONE = 4'b0000;
  localparam logic [3:0] FN_ADD  = 4'b0001;
  localparam logic [3:0] FN_SUB  = 4'b0010;

endpackage

// File: rtl/sisc_ctrl_if.sv
// Control-unit bus: IR fields and fetch handshake in, datapath controls out.
interface sisc_ctrl_if;
  logic [3:0] opcode;
  logic [3:0] mm;
  logic       imem_rdy;
  logic       ir_load;
  logic       pc_inc;
  logic [3:0] alu_op;
  logic [3:0] funct;
  logic       rf_we;
  logic       halted;

  modport master (
    input  opcode, mm, imem_rdy,
    output ir_load, pc_inc, alu_op, funct, rf_we, halted
  );

  modport slave (
    output opcode, mm, imem_rdy,
    input  ir_load, pc_inc, alu_op, funct, rf_we, halted
  );
endinterface

// File: rtl/sisc_ctrl_decode.sv
// Combinational opcode decode; opcodes 1000-1110 fall through as NOP.
module sisc_ctrl_decode
  import sisc_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [3:0] mm,
  output logic [2:0] alu_mode,
  output logic [3:0] funct,
  output logic       stat_upd,
  output logic       writes_rf,
  output logic       is_halt
);

  always_comb begin
    alu_mode  = MODE_RR;
    funct     = FN_NONE;
    stat_upd  = 1'b0;
    writes_rf = 1'b0;
    is_halt   = 1'b0;
    case (opcode)
      OP_ALU_RR: begin alu_mode = MODE_RR;   funct = mm; stat_upd = 1'b1; writes_rf = 1'b1; end
      OP_ALU_RI: begin alu_mode = MODE_RI;   funct = mm; stat_upd = 1'b1; writes_rf = 1'b1; end
      OP_ADDI:   begin alu_mode = MODE_ADDI; stat_upd = 1'b1; writes_rf = 1'b1; end
      OP_SUBI:   begin alu_mode = MODE_SUBI; stat_upd = 1'b1; writes_rf = 1'b1; end
      OP_INC:    begin alu_mode = MODE_INC;  stat_upd = 1'b1; writes_rf = 1'b1; end
      OP_DEC:    begin alu_mode = MODE_DEC;  stat_upd = 1'b1; writes_rf = 1'b1; end
      OP_MOV:    begin alu_mode = MODE_MOV;  writes_rf = 1'b1; end
      OP_HLT:    is_halt = 1'b1;
      default:   ;
    endcase
  end

endmodule

// File: rtl/sisc_ctrl.sv
// SISC multi-cycle control FSM: START -> FETCH -> DECODE -> EXECUTE -> MEM ->
// WRITEBACK, with an absorbing HALT. IR load / PC increment follow imem_rdy.
module sisc_ctrl
  import sisc_pkg::*;
#(
  parameter int unsigned START_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst_f,
  sisc_ctrl_if.master    bus
);

  state_t     state;
  logic [2:0] dec_mode;
  logic [3:0] dec_funct;
  logic       dec_stat;
  logic       dec_wr;
  logic       dec_halt;
  logic [3:0] alu_op_q;
  logic [3:0] funct_q;
  logic       rf_we_q;
  logic       halted_q;
  logic       fetch_go;

  sisc_ctrl_decode u_decode (
    .opcode    (bus.opcode),
    .mm        (bus.mm),
    .alu_mode  (dec_mode),
    .funct     (dec_funct),
    .stat_upd  (dec_stat),
    .writes_rf (dec_wr),
    .is_halt   (dec_halt)
  );

  assign fetch_go    = (state == S_FETCH) && bus.imem_rdy;
  assign bus.ir_load = fetch_go;
  assign bus.pc_inc  = fetch_go;
  assign bus.alu_op  = alu_op_q;
  assign bus.funct   = funct_q;
  assign bus.rf_we   = rf_we_q;
  assign bus.halted  = halted_q;

  // Outputs are registered one state ahead: each branch loads the values
  // the next state must present, so they are Moore-clean with no decode glitches.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state    <= S_START0;
      alu_op_q <= '0;
      funct_q  <= '0;
      rf_we_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      alu_op_q <= '0;
      funct_q  <= '0;
      rf_we_q  <= 1'b0;
      halted_q <= 1'b0;
      case (state)
        S_START0: begin
          if (START_CYCLES == 1) state <= S_FETCH;
          else                   state <= S_START1;
        end
        S_START1: state <= S_FETCH;
        S_FETCH: begin
          if (bus.imem_rdy) state <= S_DECODE;
        end
        S_DECODE: begin
          if (dec_halt) begin
            state    <= S_HALT;
            halted_q <= 1'b1;
          end else begin
            state    <= S_EXECUTE;
            alu_op_q <= {dec_mode, dec_stat};
            funct_q  <= dec_funct;
          end
        end
        S_EXECUTE: begin
          state    <= S_MEM;
          alu_op_q <= {alu_op_q[3:1], 1'b0};
          funct_q  <= funct_q;
        end
        S_MEM: begin
          state    <= S_WRITEBACK;
          alu_op_q <= alu_op_q;
          funct_q  <= funct_q;
          rf_we_q  <= dec_wr;
        end
        S_WRITEBACK: state <= S_FETCH;
        S_HALT: begin
          state    <= S_HALT;
          halted_q <= 1'b1;
        end
        default: state <= S_START0;
      endcase
    end
  end

endmodule
